scan_sig_analyzer: RTL and testbench

SCAN_SIG_ANALYZER -- requirements
Module: scan_sig_analyzer

---
 rtl/scan_sig_analyzer.sv | 112 +++++++++++
 tb/tb_scan_sig_analyzer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/scan_sig_analyzer.sv
// Scan signature analyzer: compacts CUT scan-out into a SISR, counts capture
// events, checks the shift-run length of each unload and reports pass/fail.
module scan_sig_analyzer #(
    parameter int                 SIG_W     = 16,
    parameter logic [SIG_W-1:0]   POLY      = 16'h1021,
    parameter int                 CHAIN_LEN = 4,
    parameter int                 NUM_PAT   = 32,
    parameter logic [SIG_W-1:0]   GOLDEN    = 16'h0000
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          START,
    input  logic                          SE,
    input  logic                          SO,
    output logic [SIG_W-1:0]              SIGNATURE,
    output logic [$clog2(NUM_PAT+1)-1:0]  PAT_CNT,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          PASS,
    output logic                          ERR
);
    // state | meaning
    // IDLE  | waiting for START, results held
    // RUN   | compacting scan-out, counting captures
    // DONE  | NUM_PAT captures seen, results and PASS held

    localparam int PW  = $clog2(NUM_PAT + 1);
    // one spare code above CHAIN_LEN so a saturated over-long run never aliases
    localparam int SHW = $clog2(CHAIN_LEN + 2);

    localparam logic [SHW-1:0] SH_MAX   = '1;
    localparam logic [SHW-1:0] SH_TGT   = SHW'(CHAIN_LEN);
    localparam logic [PW-1:0]  PAT_LAST = PW'(NUM_PAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [SIG_W-1:0] sig_nxt;
    logic [PW-1:0]    pat_nxt;
    logic [SHW-1:0]   sh_cnt, sh_nxt;
    logic             err_nxt;
    logic             prev_se, prev_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic             fb;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            SIGNATURE <= '0;
            PAT_CNT   <= '0;
            sh_cnt    <= '0;
            ERR       <= 1'b0;
            prev_se   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            state     <= state_nxt;
            SIGNATURE <= sig_nxt;
            PAT_CNT   <= pat_nxt;
            sh_cnt    <= sh_nxt;
            ERR       <= err_nxt;
            prev_se   <= prev_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
            PASS      <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sig_nxt   = SIGNATURE;
        pat_nxt   = PAT_CNT;
        sh_nxt    = sh_cnt;
        err_nxt   = ERR;
        prev_nxt  = prev_se;
        fb        = SIGNATURE[SIG_W-1] ^ SO;

        if (START) begin
            // restart from any state; wins over any SE activity this cycle
            state_nxt = RUN;
            sig_nxt   = '0;
            pat_nxt   = '0;
            sh_nxt    = '0;
            err_nxt   = 1'b0;
            prev_nxt  = 1'b0;
        end else if (state == RUN) begin
            prev_nxt = SE;
            if (SE) begin
                sig_nxt = {SIGNATURE[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                if (sh_cnt != SH_MAX)
                    sh_nxt = sh_cnt + SHW'(1);
            end else if (prev_se) begin
                pat_nxt = PAT_CNT + PW'(1);
                sh_nxt  = '0;
                if (sh_cnt != SH_TGT)
                    err_nxt = 1'b1;
                if (pat_nxt == PAT_LAST)
                    state_nxt = FIN;
            end
        end

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == FIN);
        pass_nxt = done_nxt && (sig_nxt == GOLDEN) && !err_nxt;
    end

endmodule

// File: tb/tb_scan_sig_analyzer.sv
// Scoreboard bench for scan_sig_analyzer: directed sessions push expected
// snapshots tagged with the clock edge; a negedge monitor pops and compares.
module tb_scan_sig_analyzer;

    logic        CLK = 1'b0;
    logic        RST_N, START, SE, SO;
    logic [15:0] SIGNATURE;
    logic [5:0]  PAT_CNT;
    logic        BUSY, DONE, PASS, ERR;

    scan_sig_analyzer dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .SE(SE), .SO(SO),
        .SIGNATURE(SIGNATURE), .PAT_CNT(PAT_CNT),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          tag;
        string       name;
        logic [15:0] sig;
        logic [5:0]  pat;
        logic        busy, done, pass, err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   edges = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // expected state kept by the stimulus side (0 idle, 1 run, 2 done)
    logic [15:0] exp_sig;
    int          exp_pat;
    logic        exp_err;
    int          exp_state;

    always @(posedge CLK) edges++;

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].tag <= edges) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (mon_e.tag != edges ||
                {SIGNATURE, PAT_CNT, BUSY, DONE, PASS, ERR} !==
                {mon_e.sig, mon_e.pat, mon_e.busy, mon_e.done, mon_e.pass, mon_e.err}) begin
                n_err++;
                $display("FAIL %s (edge %0d): got sig=%h pat=%0d busy=%b done=%b pass=%b err=%b, want sig=%h pat=%0d busy=%b done=%b pass=%b err=%b",
                         mon_e.name, edges, SIGNATURE, PAT_CNT, BUSY, DONE, PASS, ERR,
                         mon_e.sig, mon_e.pat[5:0], mon_e.busy, mon_e.done, mon_e.pass, mon_e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got still running, want finished");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic st, input logic se, input logic so);
        START = st;
        SE    = se;
        SO    = so;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name);
        exp_t e;
        e.tag  = edges;
        e.name = name;
        e.sig  = exp_sig;
        e.pat  = 6'(exp_pat);
        e.busy = (exp_state == 1);
        e.done = (exp_state == 2);
        e.pass = (exp_state == 2) && (exp_sig == 16'h0000) && !exp_err;
        e.err  = exp_err;
        sb.push_back(e);
    endtask

    task automatic clear_exp(input int st);
        exp_sig   = 16'h0000;
        exp_pat   = 0;
        exp_err   = 1'b0;
        exp_state = st;
    endtask

    task automatic start_session(input logic se, input logic so, input string name);
        drive(1'b1, se, so);
        clear_exp(1);
        chk(name);
    endtask

    // nshift SE=1 cycles then one capture cycle; inject drives SO=1 on the
    // last shift, applied only when the signature is zero so it lands at 1021
    task automatic run_pattern(input int nshift, input bit inject, input string name);
        for (int i = 0; i < nshift; i++) begin
            drive(1'b0, 1'b1, inject && (i == nshift - 1));
            if (inject && (i == nshift - 1) && exp_state == 1) begin
                exp_sig = 16'h1021;
                chk({name, "_inject"});
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        if (exp_state == 1) begin
            exp_pat++;
            if (nshift != 4) exp_err = 1'b1;
            if (exp_pat == 32) exp_state = 2;
        end
        chk(name);
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b1; SE = 1'b1; SO = 1'b1;
        clear_exp(0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("reset_over_start");
        RST_N = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        chk("idle_ignores_se");

        // two shifts, short unload, then idle capture cycle
        start_session(1'b0, 1'b0, "start_from_idle");
        drive(1'b0, 1'b1, 1'b1);
        exp_sig = 16'h1021; chk("sisr_so1");
        drive(1'b0, 1'b1, 1'b0);
        exp_sig = 16'h2042; chk("sisr_so0");
        drive(1'b0, 1'b0, 1'b0);
        exp_pat = 1; exp_err = 1'b1; chk("short_capture");
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("idle_capture_hold");

        // over-long run must saturate rather than wrap back onto CHAIN_LEN
        start_session(1'b0, 1'b0, "restart_clears_err");
        run_pattern(12, 1'b0, "long_run_err");

        // clean session
        start_session(1'b0, 1'b0, "start_clean");
        for (int p = 1; p <= 32; p++) run_pattern(4, 1'b0, $sformatf("clean_p%0d", p));
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        chk("done_hold");

        // pattern 5 short
        start_session(1'b0, 1'b0, "start_from_done");
        for (int p = 1; p <= 32; p++) run_pattern((p == 5) ? 3 : 4, 1'b0, $sformatf("bad5_p%0d", p));

        // SO=1 on the final shift
        start_session(1'b0, 1'b0, "start_sig");
        for (int p = 1; p <= 32; p++) run_pattern(4, (p == 32), $sformatf("sig_p%0d", p));

        // reset in the middle of a session
        start_session(1'b0, 1'b0, "start_rst");
        for (int p = 1; p <= 10; p++) run_pattern(4, (p == 10), $sformatf("rst_p%0d", p));
        RST_N = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        clear_exp(0); chk("mid_run_reset");
        RST_N = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("post_reset_idle_a");
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("post_reset_idle_b");

        // restart mid-run after pattern 7, START coincident with a shift
        start_session(1'b0, 1'b0, "start_mid");
        for (int p = 1; p <= 7; p++) run_pattern((p == 2) ? 3 : 4, (p == 7), $sformatf("mid_p%0d", p));
        start_session(1'b1, 1'b1, "restart_in_run");
        for (int p = 1; p <= 32; p++) run_pattern(4, 1'b0, $sformatf("after_restart_p%0d", p));

        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
